// File: rtl/regfile_fwd_pkg.sv
// Shared constants and types for the decode-stage register file and its forwarding network.
// The ALU opcode set lives here so that execute and decode agree on one encoding.
package regfile_fwd_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;
    localparam logic [ADDR_W-1:0] REG_ZERO  = '0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_LUI  = 4'hA
    } alu_op_e;

    // True when a pipeline-stage write targets the register being read.
    function automatic logic stage_hit(input logic we,
                                       input logic [ADDR_W-1:0] waddr,
                                       input logic [ADDR_W-1:0] raddr);
        return we && (waddr == raddr);
    endfunction

endpackage

// File: rtl/regfile_fwd_if.sv
// Decode read ports plus the EX/MEM/WB write-side signals seen by the register file.
// master drives requests (pipeline), slave is the register file.
interface regfile_fwd_if;
    import regfile_fwd_pkg::*;

    logic              re1_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata1_o;
    logic [DATA_W-1:0] rdata2_o;

    logic              ex_we_i;
    logic [ADDR_W-1:0] ex_waddr_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic              ex_is_load_i;

    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_waddr_i;
    logic [DATA_W-1:0] mem_wdata_i;

    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_waddr_i;
    logic [DATA_W-1:0] wb_wdata_i;

    logic              stall_req_o;

    modport master (
        output re1_i, raddr1_i, re2_i, raddr2_i,
        output ex_we_i, ex_waddr_i, ex_wdata_i, ex_is_load_i,
        output mem_we_i, mem_waddr_i, mem_wdata_i,
        output wb_we_i, wb_waddr_i, wb_wdata_i,
        input  rdata1_o, rdata2_o, stall_req_o
    );

    modport slave (
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        input  ex_we_i, ex_waddr_i, ex_wdata_i, ex_is_load_i,
        input  mem_we_i, mem_waddr_i, mem_wdata_i,
        input  wb_we_i, wb_waddr_i, wb_wdata_i,
        output rdata1_o, rdata2_o, stall_req_o
    );

endinterface

// File: rtl/regfile_array.sv
// Architectural register storage: one write port, two raw asynchronous read ports.
// Whole array clears on reset, so entries are never X; register 0 is never written.
module regfile_array
    import regfile_fwd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_num_regs
        $error("NUM_REGS must equal 2**ADDR_W");
    end

    logic [DATA_W-1:0] mem_reg [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_reg[i] <= ZERO_WORD;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata1 = mem_reg[raddr1];
    assign rdata2 = mem_reg[raddr2];

endmodule

// File: rtl/regfile_fwd.sv
// Decode-stage register file with EX/MEM/WB operand forwarding and load-use hazard detect.
// Reads are combinational; the youngest matching pipeline stage wins.
module regfile_fwd
    import regfile_fwd_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    regfile_fwd_if.slave bus
);

    logic [DATA_W-1:0] raw1;
    logic [DATA_W-1:0] raw2;
    logic [1:0]        load_hit;
    logic              ex_fwd_ok;
    logic              ex_load_pending;

    regfile_array u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_we_i),
        .waddr  (bus.wb_waddr_i),
        .wdata  (bus.wb_wdata_i),
        .raddr1 (bus.raddr1_i),
        .raddr2 (bus.raddr2_i),
        .rdata1 (raw1),
        .rdata2 (raw2)
    );

    // A load in EX has no data yet: it never forwards, it only raises the hazard.
    assign ex_fwd_ok       = bus.ex_we_i && !bus.ex_is_load_i;
    assign ex_load_pending = bus.ex_we_i && bus.ex_is_load_i && (bus.ex_waddr_i != REG_ZERO);

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              port_re;
        logic [ADDR_W-1:0] port_addr;
        logic [DATA_W-1:0] raw_data;
        logic [DATA_W-1:0] rd;

        assign port_re   = (gi == 0) ? bus.re1_i    : bus.re2_i;
        assign port_addr = (gi == 0) ? bus.raddr1_i : bus.raddr2_i;
        assign raw_data  = (gi == 0) ? raw1         : raw2;

        always_comb begin
            rd = ZERO_WORD;
            if (!rst && port_re && (port_addr != REG_ZERO)) begin
                if (stage_hit(ex_fwd_ok, bus.ex_waddr_i, port_addr)) begin
                    rd = bus.ex_wdata_i;
                end else if (stage_hit(bus.mem_we_i, bus.mem_waddr_i, port_addr)) begin
                    rd = bus.mem_wdata_i;
                end else if (stage_hit(bus.wb_we_i, bus.wb_waddr_i, port_addr)) begin
                    rd = bus.wb_wdata_i;
                end else begin
                    rd = raw_data;
                end
            end
        end

        assign load_hit[gi] = port_re && (port_addr == bus.ex_waddr_i);
    end

    assign bus.rdata1_o    = g_port[0].rd;
    assign bus.rdata2_o    = g_port[1].rd;
    assign bus.stall_req_o = !rst && ex_load_pending && (|load_hit);

endmodule
